// File: rtl/vjtag_cmd_decoder.sv
// vjtag_cmd_decoder: decodes host-written virtual-JTAG bytes into checked 5-byte commands
module vjtag_cmd_decoder #(
   parameter int         SYNC_STAGES = 2,
   parameter logic [7:0] SOF_BYTE    = 8'hA5,
   parameter logic [1:0] IR_WRITE    = 2'd1,
   parameter int         TIMEOUT_CYC = 1000000
) (
   input  logic       clk,
   input  logic       aclr,
   input  logic       v_udr,
   input  logic [1:0] ir_in,
   input  logic [7:0] data_from_pc,
   input  logic       clear_err,
   output logic       cmd_valid,
   input  logic       cmd_ready,
   output logic [7:0] cmd_opcode,
   output logic [7:0] cmd_addr,
   output logic [7:0] cmd_wdata,
   output logic [7:0] status
);

   localparam int            CW     = $clog2(TIMEOUT_CYC);
   localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT_CYC - 1);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_OPC  = 3'd1;
   localparam logic [2:0] S_ADR  = 3'd2;
   localparam logic [2:0] S_DAT  = 3'd3;
   localparam logic [2:0] S_CHK  = 3'd4;

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   hist_q, hist_d;
   logic [7:0]             byte_q, byte_d;
   logic                   stb_q, stb_d;
   logic [2:0]             state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [7:0]             opc_q, opc_d, adr_q, adr_d, dat_q, dat_d;
   logic                   cmd_valid_q, cmd_valid_d;
   logic [7:0]             cmd_opcode_q, cmd_opcode_d;
   logic [7:0]             cmd_addr_q, cmd_addr_d;
   logic [7:0]             cmd_wdata_q, cmd_wdata_d;
   logic                   err_t_q, err_t_d, err_c_q, err_c_d, err_o_q, err_o_d;
   logic [7:0]             status_q, status_d;
   logic                   fall, at_chk, chk_ok, slot_free, load, tmo;

   // v_udr synchronizer and falling-edge capture; data_from_pc is stable at the fall
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], v_udr};
      hist_d = sync_q[SYNC_STAGES-1];
      fall   = hist_q & ~sync_q[SYNC_STAGES-1];
      byte_d = fall ? data_from_pc : byte_q;
      stb_d  = fall & (ir_in == IR_WRITE);
   end

   // packet decode decisions: checksum, output slot availability, inter-byte timeout
   always_comb begin
      at_chk    = stb_q & (state_q == S_CHK);
      chk_ok    = byte_q == (opc_q ^ adr_q ^ dat_q);
      slot_free = ~cmd_valid_q | cmd_ready;
      load      = at_chk & chk_ok & slot_free;
      tmo       = ~stb_q & (state_q != S_IDLE) & (cnt_q == T_LAST);
   end

   // frame state machine, stepped by one captured byte at a time
   always_comb begin
      state_d = state_q;
      if (stb_q) begin
         case (state_q)
            S_IDLE:  state_d = (byte_q == SOF_BYTE) ? S_OPC : S_IDLE;
            S_OPC:   state_d = S_ADR;
            S_ADR:   state_d = S_DAT;
            S_DAT:   state_d = S_CHK;
            default: state_d = S_IDLE;
         endcase
      end else if (tmo) begin
         state_d = S_IDLE;
      end
   end

   // shadow fields, timeout counter, command slot, sticky errors and status image
   always_comb begin
      opc_d        = (stb_q & (state_q == S_OPC)) ? byte_q : opc_q;
      adr_d        = (stb_q & (state_q == S_ADR)) ? byte_q : adr_q;
      dat_d        = (stb_q & (state_q == S_DAT)) ? byte_q : dat_q;
      cnt_d        = (stb_q | (state_q == S_IDLE) | tmo) ? '0 : cnt_q + 1'b1;
      cmd_valid_d  = load | (cmd_valid_q & ~cmd_ready);
      cmd_opcode_d = load ? opc_q : cmd_opcode_q;
      cmd_addr_d   = load ? adr_q : cmd_addr_q;
      cmd_wdata_d  = load ? dat_q : cmd_wdata_q;
      err_t_d      = tmo | (err_t_q & ~clear_err);
      err_c_d      = (at_chk & ~chk_ok) | (err_c_q & ~clear_err);
      err_o_d      = (at_chk & chk_ok & ~slot_free) | (err_o_q & ~clear_err);
      status_d     = {err_t_d, err_c_d, err_o_d, cmd_valid_d, 1'b0, state_d};
   end

   // state registers with synchronous reset
   always_ff @(posedge clk) begin
      if (aclr) begin
         sync_q       <= '0;
         hist_q       <= 1'b0;
         byte_q       <= '0;
         stb_q        <= 1'b0;
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         opc_q        <= '0;
         adr_q        <= '0;
         dat_q        <= '0;
         cmd_valid_q  <= 1'b0;
         cmd_opcode_q <= '0;
         cmd_addr_q   <= '0;
         cmd_wdata_q  <= '0;
         err_t_q      <= 1'b0;
         err_c_q      <= 1'b0;
         err_o_q      <= 1'b0;
         status_q     <= '0;
      end else begin
         sync_q       <= sync_d;
         hist_q       <= hist_d;
         byte_q       <= byte_d;
         stb_q        <= stb_d;
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         opc_q        <= opc_d;
         adr_q        <= adr_d;
         dat_q        <= dat_d;
         cmd_valid_q  <= cmd_valid_d;
         cmd_opcode_q <= cmd_opcode_d;
         cmd_addr_q   <= cmd_addr_d;
         cmd_wdata_q  <= cmd_wdata_d;
         err_t_q      <= err_t_d;
         err_c_q      <= err_c_d;
         err_o_q      <= err_o_d;
         status_q     <= status_d;
      end
   end

   assign cmd_valid  = cmd_valid_q;
   assign cmd_opcode = cmd_opcode_q;
   assign cmd_addr   = cmd_addr_q;
   assign cmd_wdata  = cmd_wdata_q;
   assign status     = status_q;

endmodule
